// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32 constants, divider FSM states and field helpers.
package fp32_pkg;
  localparam int          BIAS   = 127;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam int          EXP_W  = 8;
  localparam int          MANT_W = 23;
  localparam int          QBITS  = 26;
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_e;
  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction
  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction
  function automatic logic [MANT_W-1:0] f_mant(input logic [31:0] x);
    return x[22:0];
  endfunction
endpackage

// File: rtl/fdiv_mant_core.sv
// fdiv_mant_core: restoring mantissa divider, one quotient bit per clock.
module fdiv_mant_core
  import fp32_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [MANT_W-1:0] ma_i,
  input  logic [MANT_W-1:0] mb_i,
  output logic              done_o,
  output logic [QBITS-1:0]  q_o,
  output logic              rem_nz_o
);
  logic             busy_q;
  logic [4:0]       cnt_q;
  logic [24:0]      rem_q;
  logic [23:0]      div_q;
  logic [QBITS-1:0] q_q;
  logic [25:0]      trial;
  logic             ge;
  logic [24:0]      sel;
  always_comb begin
    trial = {1'b0, rem_q} - {2'b0, div_q};
    ge    = ~trial[25];
    sel   = ge ? trial[24:0] : rem_q;
  end
  assign done_o   = busy_q & (cnt_q == 5'd25);
  assign q_o      = q_q;
  assign rem_nz_o = |rem_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      q_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= {2'b01, ma_i};
      div_q  <= {1'b1, mb_i};
      q_q    <= '0;
    end else if (busy_q) begin
      rem_q  <= sel << 1;
      q_q    <= {q_q[QBITS-2:0], ge};
      cnt_q  <= cnt_q + 5'd1;
      busy_q <= ~done_o;
    end
  end
endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential fp32 divider c = a / b with valid/ready handshakes.
module fdiv_seq
  import fp32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] c_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);
  state_e             state_q, state_d;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [31:0]        c_q, c_d;
  logic [7:0]         ea, eb;
  logic               a_z, b_z, a_sp, b_sp, special, acc, start, done, rem_nz;
  logic [QBITS-1:0]   q;
  logic [31:0]        spec_res, res;
  logic               norm, g, s;
  logic [22:0]        mant_pre;
  logic [23:0]        mant_r;
  logic signed [9:0]  e_n, e_r;
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign c_o         = c_q;
  assign ea      = f_exp(a_i);
  assign eb      = f_exp(b_i);
  assign a_z     = (ea == 8'h00);
  assign b_z     = (eb == 8'h00);
  assign a_sp    = (ea == 8'hFF);
  assign b_sp    = (eb == 8'hFF);
  assign special = a_sp | b_sp | a_z | b_z;
  assign acc     = in_valid_i & in_ready_o;
  assign start   = acc & ~special;
  assign spec_res = (a_sp | b_sp | (a_z & b_z)) ? QNAN :
                    b_z ? {f_sign(a_i) ^ f_sign(b_i), 8'hFF, 23'h0} : 32'h0;
  fdiv_mant_core u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .ma_i     (f_mant(a_i)),
    .mb_i     (f_mant(b_i)),
    .done_o   (done),
    .q_o      (q),
    .rem_nz_o (rem_nz)
  );
  // a quotient below 1.0 leaves q[25] clear and costs one exponent step
  always_comb begin
    norm     = q[25];
    mant_pre = norm ? q[24:2] : q[23:1];
    g        = norm ? q[1] : q[0];
    s        = (norm & q[0]) | rem_nz;
    e_n      = norm ? exp_q : exp_q - 10'sd1;
    mant_r   = {1'b0, mant_pre} + {23'd0, g & (s | mant_pre[0])};
    e_r      = e_n + $signed({9'd0, mant_r[23]});
    res      = (e_r >= 10'sd255) ? {sign_q, 8'hFF, 23'h0} :
               (e_r <= 10'sd0)   ? 32'h0 : {sign_q, e_r[7:0], mant_r[22:0]};
  end
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = special ? DONE : DIV;
        c_d     = special ? spec_res : c_q;
      end
      DIV:   state_d = done ? ROUND : DIV;
      ROUND: begin
        state_d = DONE;
        c_d     = res;
      end
      DONE:  state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      if (acc) begin
        sign_q <= f_sign(a_i) ^ f_sign(b_i);
        exp_q  <= $signed({2'b0, ea}) - $signed({2'b0, eb}) + $signed(10'(BIAS));
      end
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: randomized and directed checks of fdiv_seq against an arithmetic model.
module tb_fdiv_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_i, b_i, c_o;
  logic        in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  fdiv_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .a_i         (a_i),
    .b_i         (b_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .c_o         (c_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF;
  endfunction

  // quotient computed directly as an integer ratio scaled to 24+2 significant bits
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic        sg;
    logic [63:0] na, nb, num, qq, rr, m;
    logic        gb, sb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sg = a[31] ^ b[31];
    if (ea == 255 || eb == 255) return 32'h7FC0_0000;
    if (ea == 0 && eb == 0) return 32'h7FC0_0000;
    if (eb == 0) return {sg, 8'hFF, 23'h0};
    if (ea == 0) return 32'h0;
    na = {40'd1, a[22:0]};
    nb = {40'd1, b[22:0]};
    if (na >= nb) begin
      e = ea - eb + 127;
      num = na << 25;
    end else begin
      e = ea - eb + 126;
      num = na << 26;
    end
    qq = num / nb;
    rr = num % nb;
    m  = qq >> 2;
    gb = qq[1];
    sb = qq[0] | (rr != 0);
    if (gb && (sb || m[0])) m = m + 1;
    if (m == 64'h100_0000) begin
      m = 64'h80_0000;
      e = e + 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {sg, 8'(e), m[22:0]};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid got=%h want=none", c_o);
      end else begin
        chk("model_cmp", c_o, exp_q[0]);
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int   n;
    n = 0;
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      rdy = in_ready_o;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL accept_timeout got=busy want=ready");
        break;
      end
    end
    exp_q.push_back(model(a, b));
    #1;
    in_valid_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
  endtask

  // lat counts the cycle right after the accept edge as cycle 1
  task automatic wait_valid(output int lat, output logic ir_seen);
    lat = 1;
    ir_seen = 1'b0;
    while (!out_valid_o && lat < 60) begin
      ir_seen |= in_ready_o;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
  endtask

  task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] lit, input int lat_want);
    int   lat;
    logic ir;
    chk({nm, "_model"}, model(a, b), lit);
    accept(a, b);
    wait_valid(lat, ir);
    chk({nm, "_lat"}, 32'(lat), 32'(lat_want));
    chk({nm, "_c"}, c_o, lit);
    chk({nm, "_inready_low"}, {31'd0, ir}, 32'd0);
    drain();
    chk({nm, "_inready_back"}, {31'd0, in_ready_o}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_fp();
    int         k;
    logic [7:0] e;
    k = $urandom_range(0, 15);
    e = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF :
        (k < 5) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(110, 144));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    int          lat, r, n;
    logic        ir;
    logic [31:0] a, b;
    rst = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_c", c_o, 32'h0);
    rst = 1'b0;

    op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28);
    op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 28);
    op("one_by_one", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 28);
    op("neg_by_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1);
    op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1);
    op("zero_by_five", 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1);
    op("inf_by_one", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1);
    op("overflow", 32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 28);
    op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 28);

    accept(32'h40C0_0000, 32'h4000_0000);
    wait_valid(lat, ir);
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk);
      #1;
      chk("bp_c", c_o, 32'h4040_0000);
      chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_inready", {31'd0, in_ready_o}, 32'd0);
    end
    in_valid_i = 1'b0;
    drain();
    chk("bp_release_inready", {31'd0, in_ready_o}, 32'd1);

    accept(32'h40C0_0000, 32'h4000_0000);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_c", c_o, 32'h0);
    rst = 1'b0;
    op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28);

    for (int i = 0; i < 60; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      accept(a, b);
      wait_valid(lat, ir);
      chk("rnd_lat", 32'(lat), is_special(a, b) ? 32'd1 : 32'd28);
      n = 0;
      do begin
        r = $urandom_range(0, 1);
        out_ready_i = 1'(r);
        @(posedge clk);
        #1;
        n++;
      end while (r == 0 && n < 50);
      out_ready_i = 1'b0;
    end
    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
